// File: rtl/banco_registros_sb_if.sv
// Register-file bundle: two read ports, one write port, scoreboard issue/query and dump stream.
// master = pipeline/debug side, slave = register file.
interface banco_registros_sb_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic [AW-1:0]   read_r1;
  logic [AW-1:0]   read_r2;
  logic [XLEN-1:0] data_r1;
  logic [XLEN-1:0] data_r2;
  logic            RegWriteEn;
  logic [AW-1:0]   rd;
  logic [XLEN-1:0] data;
  logic            issue_en;
  logic [AW-1:0]   issue_rd;
  logic            busy_r1;
  logic            busy_r2;
  logic            dump_req;
  logic            dump_busy;
  logic            dump_valid;
  logic [AW-1:0]   dump_idx;
  logic [XLEN-1:0] dump_data;
  logic            dump_ready;

  modport master (
    output read_r1, read_r2, RegWriteEn, rd, data, issue_en, issue_rd, dump_req, dump_ready,
    input  data_r1, data_r2, busy_r1, busy_r2, dump_busy, dump_valid, dump_idx, dump_data
  );

  modport slave (
    input  read_r1, read_r2, RegWriteEn, rd, data, issue_en, issue_rd, dump_req, dump_ready,
    output data_r1, data_r2, busy_r1, busy_r2, dump_busy, dump_valid, dump_idx, dump_data
  );
endinterface

// File: rtl/banco_registros_sb.sv
// RV32I register file with busy scoreboard and dump engine; reads/busy are zero-latency, writes land at posedge.
// Dump beats are valid/ready: index holds while dump_ready is low, dump_data follows live contents.
module banco_registros_sb #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  banco_registros_sb_if.slave  bus
);
  localparam int NREG = 2 ** AW;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SCAN = 1'b1;

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] sb;
  logic [0:0]      state;
  logic [AW-1:0]   dump_idx_q;
  logic            wr_ok;

  // Ports 0/1 are the pipeline reads, port 2 is the dump engine; all share one rule set.
  logic [AW-1:0]   raddr [3];
  logic [XLEN-1:0] rval  [3];

  assign wr_ok = bus.RegWriteEn && ((bus.rd != '0) || (ZERO_REG == 0));

  assign raddr[0] = bus.read_r1;
  assign raddr[1] = bus.read_r2;
  assign raddr[2] = dump_idx_q;

  always_comb begin
    for (int p = 0; p < 3; p++) begin
      rval[p] = regs[raddr[p]];
      if ((ZERO_REG != 0) && (raddr[p] == '0))
        rval[p] = '0;
      if ((BYPASS != 0) && wr_ok && (bus.rd == raddr[p]))
        rval[p] = bus.data;
    end
  end

  assign bus.data_r1   = rval[0];
  assign bus.data_r2   = rval[1];
  assign bus.dump_data = rval[2];

  // A bypassed write delivers the pending value this cycle, so the hazard is already resolved.
  assign bus.busy_r1 = sb[bus.read_r1] && !((BYPASS != 0) && bus.RegWriteEn && (bus.rd == bus.read_r1));
  assign bus.busy_r2 = sb[bus.read_r2] && !((BYPASS != 0) && bus.RegWriteEn && (bus.rd == bus.read_r2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
    end else if (wr_ok) begin
      regs[bus.rd] <= bus.data;
    end
  end

  // Issue is applied after the write clear so a new producer on the same register wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb <= '0;
    end else begin
      if (wr_ok)
        sb[bus.rd] <= 1'b0;
      if (bus.issue_en)
        sb[bus.issue_rd] <= 1'b1;
      if (ZERO_REG != 0)
        sb[0] <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      dump_idx_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.dump_req) begin
            state      <= S_SCAN;
            dump_idx_q <= '0;
          end
        end
        default: begin
          if (bus.dump_ready) begin
            if (&dump_idx_q) begin
              state      <= S_IDLE;
              dump_idx_q <= '0;
            end else begin
              dump_idx_q <= dump_idx_q + 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign bus.dump_busy  = (state == S_SCAN);
  assign bus.dump_valid = (state == S_SCAN);
  assign bus.dump_idx   = dump_idx_q;
endmodule

// File: tb/tb_banco_registros_sb.sv
// Directed bench for banco_registros_sb; a second BYPASS=0 instance mirrors the pipeline inputs
// so forwarding and non-forwarding behaviour can be compared on identical stimulus.
module tb_banco_registros_sb;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  banco_registros_sb_if #(.XLEN(32), .AW(5)) ifa ();
  banco_registros_sb_if #(.XLEN(32), .AW(5)) ifn ();

  banco_registros_sb #(.XLEN(32), .AW(5), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  banco_registros_sb #(.XLEN(32), .AW(5), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk (clk),
    .rst (rst),
    .bus (ifn)
  );

  assign ifn.read_r1    = ifa.read_r1;
  assign ifn.read_r2    = ifa.read_r2;
  assign ifn.RegWriteEn = ifa.RegWriteEn;
  assign ifn.rd         = ifa.rd;
  assign ifn.data       = ifa.data;
  assign ifn.issue_en   = ifa.issue_en;
  assign ifn.issue_rd   = ifa.issue_rd;
  assign ifn.dump_req   = 1'b0;
  assign ifn.dump_ready = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] v);
    ifa.RegWriteEn = 1'b1;
    ifa.rd         = a;
    ifa.data       = v;
    @(posedge clk); #1;
    ifa.RegWriteEn = 1'b0;
  endtask

  initial begin
    int beats;
    n_chk = 0;
    n_pass = 0;
    rst = 1'b1;
    ifa.read_r1 = '0; ifa.read_r2 = '0;
    ifa.RegWriteEn = 1'b0; ifa.rd = '0; ifa.data = '0;
    ifa.issue_en = 1'b0; ifa.issue_rd = '0;
    ifa.dump_req = 1'b0; ifa.dump_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    for (int a = 0; a < 32; a++) begin
      ifa.read_r1 = 5'(a);
      ifa.read_r2 = 5'(31 - a);
      #1;
      chk("rst_data_r1", ifa.data_r1, 32'd0);
      chk("rst_data_r2", ifa.data_r2, 32'd0);
      chk("rst_busy_r1", {31'd0, ifa.busy_r1}, 32'd0);
    end
    chk("rst_dump_busy", {31'd0, ifa.dump_busy}, 32'd0);
    chk("rst_dump_valid", {31'd0, ifa.dump_valid}, 32'd0);
    chk("rst_dump_idx", {27'd0, ifa.dump_idx}, 32'd0);

    // Basic write/read and x0
    wr(5'd3, 32'd45);
    ifa.read_r1 = 5'd3; ifa.read_r2 = 5'd2; #1;
    chk("wr_x3", ifa.data_r1, 32'd45);
    chk("rd_x2", ifa.data_r2, 32'd0);
    ifa.RegWriteEn = 1'b1; ifa.rd = 5'd0; ifa.data = 32'hDEAD; ifa.read_r1 = 5'd0; ifa.read_r2 = 5'd3; #1;
    chk("x0_nobypass", ifa.data_r1, 32'd0);
    chk("same_cycle_other", ifa.data_r2, 32'd45);
    @(posedge clk); #1 ifa.RegWriteEn = 1'b0; #1;
    chk("x0_after", ifa.data_r1, 32'd0);

    // Bypass
    ifa.RegWriteEn = 1'b1; ifa.rd = 5'd5; ifa.data = 32'h1234; ifa.read_r1 = 5'd5; ifa.read_r2 = 5'd5; #1;
    chk("bypass_r1", ifa.data_r1, 32'h1234);
    chk("bypass_r2", ifa.data_r2, 32'h1234);
    chk("nobypass_r1", ifn.data_r1, 32'd0);
    @(posedge clk); #1 ifa.RegWriteEn = 1'b0; #1;
    chk("x5_after", ifa.data_r1, 32'h1234);
    chk("x5_after_nb", ifn.data_r1, 32'h1234);

    // Scoreboard
    ifa.issue_en = 1'b1; ifa.issue_rd = 5'd7;
    @(posedge clk); #1 ifa.issue_en = 1'b0;
    ifa.read_r1 = 5'd7; ifa.read_r2 = 5'd2; #1;
    chk("sb_set", {31'd0, ifa.busy_r1}, 32'd1);
    chk("sb_other", {31'd0, ifa.busy_r2}, 32'd0);
    ifa.RegWriteEn = 1'b1; ifa.rd = 5'd7; ifa.data = 32'd9; #1;
    chk("sb_bypass_clear", {31'd0, ifa.busy_r1}, 32'd0);
    chk("sb_bypass_data", ifa.data_r1, 32'd9);
    chk("sb_nb_still_busy", {31'd0, ifn.busy_r1}, 32'd1);
    @(posedge clk); #1 ifa.RegWriteEn = 1'b0; #1;
    chk("sb_cleared", {31'd0, ifa.busy_r1}, 32'd0);
    chk("sb_nb_cleared", {31'd0, ifn.busy_r1}, 32'd0);
    chk("x7_val", ifa.data_r1, 32'd9);
    ifa.issue_en = 1'b1; ifa.issue_rd = 5'd7;
    ifa.RegWriteEn = 1'b1; ifa.rd = 5'd7; ifa.data = 32'd10;
    @(posedge clk); #1 ifa.issue_en = 1'b0; ifa.RegWriteEn = 1'b0; #1;
    chk("sb_set_wins", {31'd0, ifa.busy_r1}, 32'd1);
    chk("x7_val2", ifa.data_r1, 32'd10);
    wr(5'd7, 32'd21); #1;
    chk("sb_clear2", {31'd0, ifa.busy_r1}, 32'd0);
    ifa.issue_en = 1'b1; ifa.issue_rd = 5'd0;
    @(posedge clk); #1 ifa.issue_en = 1'b0; ifa.read_r2 = 5'd0; #1;
    chk("sb_x0_never", {31'd0, ifa.busy_r2}, 32'd0);

    // Dump with ready held high
    for (int i = 1; i < 32; i++) wr(5'(i), 32'(i * 3));
    ifa.dump_ready = 1'b1; ifa.dump_req = 1'b1;
    @(posedge clk); #1 ifa.dump_req = 1'b0; #1;
    for (int b = 0; b < 32; b++) begin
      chk("dump_valid", {31'd0, ifa.dump_valid}, 32'd1);
      chk("dump_idx", {27'd0, ifa.dump_idx}, 32'(b));
      chk("dump_data", ifa.dump_data, 32'(b * 3));
      @(posedge clk); #2;
    end
    chk("dump_done_busy", {31'd0, ifa.dump_busy}, 32'd0);
    chk("dump_done_idx", {27'd0, ifa.dump_idx}, 32'd0);

    // Dump with ready toggling and a stray request mid-scan
    ifa.dump_ready = 1'b0; ifa.dump_req = 1'b1;
    @(posedge clk); #1 ifa.dump_req = 1'b0;
    beats = 0;
    for (int cyc = 0; cyc < 200 && beats < 32; cyc++) begin
      ifa.dump_ready = cyc[0];
      ifa.dump_req   = (cyc == 9);
      #1;
      if (ifa.dump_valid && ifa.dump_ready) begin
        chk("tog_idx", {27'd0, ifa.dump_idx}, 32'(beats));
        chk("tog_data", ifa.dump_data, 32'(beats * 3));
        beats++;
      end
      @(posedge clk); #1;
    end
    ifa.dump_ready = 1'b0; ifa.dump_req = 1'b0; #1;
    chk("tog_beats", 32'(beats), 32'd32);
    chk("tog_done_busy", {31'd0, ifa.dump_busy}, 32'd0);

    // Reset during beat 10
    ifa.dump_ready = 1'b1; ifa.dump_req = 1'b1;
    @(posedge clk); #1 ifa.dump_req = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_idx", {27'd0, ifa.dump_idx}, 32'd10);
    chk("mid_data", ifa.dump_data, 32'd30);
    rst = 1'b1; #1;
    chk("abort_valid", {31'd0, ifa.dump_valid}, 32'd0);
    chk("abort_busy", {31'd0, ifa.dump_busy}, 32'd0);
    chk("abort_idx", {27'd0, ifa.dump_idx}, 32'd0);
    ifa.read_r1 = 5'd31; ifa.read_r2 = 5'd3; #1;
    chk("abort_x31", ifa.data_r1, 32'd0);
    chk("abort_x3", ifa.data_r2, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_abort_valid", {31'd0, ifa.dump_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
